// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// ysyx_23060332_mem_arbiter_if: IFU, LSU and memory port bundle around the arbiter
interface ysyx_23060332_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_err;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [7:0]        lsu_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_err;
    logic [DATA_W-1:0] lsu_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side: serves the requesters, masters the memory port
    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    // environment side: the two requesters and the memory
    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// ysyx_23060332_mem_arbiter: IFU/LSU onto one memory port with per-transaction timeout; define ARB_RR_EN for round-robin arbitration
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic clk,
    input logic rst_n,
    ysyx_23060332_mem_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic              owner_lsu, wen_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [7:0]        wmask_q;
    logic [CW-1:0]     cnt;
    logic              grant_lsu, hs, to, ifu_sel, lsu_sel;

`ifdef ARB_RR_EN
    logic last_lsu;
    assign grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_lsu);
    // remember who won the last handshake so the other side wins a tie
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_lsu <= 1'b0;
        else if (hs) last_lsu <= grant_lsu;
`else
    assign grant_lsu = bus.lsu_req_valid;
`endif

    assign hs      = (state == IDLE) & (bus.ifu_req_valid | bus.lsu_req_valid);
    assign to      = cnt == CNT_LAST;
    assign ifu_sel = (state == RESP) & ~owner_lsu;
    assign lsu_sel = (state == RESP) & owner_lsu;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next state plus the handshake and response strobes
    always_comb begin
        state_nx           = state;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.lsu_req_ready = grant_lsu;
                bus.ifu_req_ready = bus.ifu_req_valid & ~grant_lsu;
                if (hs) state_nx = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_nx = WAIT;
            end
            WAIT: if (bus.mem_resp_valid | to) state_nx = RESP;
            RESP: begin
                bus.ifu_resp_valid = ~owner_lsu;
                bus.lsu_resp_valid = owner_lsu;
                state_nx           = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // capture the granted request, count WAIT cycles and latch the reply
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner_lsu <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= 8'h0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            if (hs) begin
                owner_lsu <= grant_lsu;
                wen_q     <= grant_lsu & bus.lsu_wen;
                addr_q    <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                wdata_q   <= (grant_lsu & bus.lsu_wen) ? bus.lsu_wdata : '0;
                wmask_q   <= (grant_lsu & bus.lsu_wen) ? bus.lsu_wmask : 8'h0;
            end
            if (state == WAIT) begin
                cnt <= (bus.mem_resp_valid | to) ? '0 : cnt + 1'b1;
                if (bus.mem_resp_valid) begin
                    rdata_q <= wen_q ? '0 : bus.mem_rdata;
                    err_q   <= 1'b0;
                end else if (to) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end

    assign bus.mem_wen      = wen_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wmask    = wmask_q;
    assign bus.ifu_resp_err = ifu_sel & err_q;
    assign bus.lsu_resp_err = lsu_sel & err_q;
    assign bus.ifu_rdata    = ifu_sel ? rdata_q : '0;
    assign bus.lsu_rdata    = lsu_sel ? rdata_q : '0;
endmodule
